keypad_digit_display: RTL and testbench



---
 rtl/keypad_digit_display.sv | 163 ++++++++++++++++
 tb/tb_keypad_digit_display.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_digit_display.sv
// keypad_digit_display
//   Consumes the keypad scanner's key-valid strobe and key code. It keeps an
//   8-digit decimal entry buffer, with backspace (0xB) and clear (0xC). It
//   drives an 8-digit multiplexed common-anode seven-segment display.
//
// Ports
//   clk          system clock, all state on rising edge
//   reset        synchronous active-low reset
//   keyboard_en  key-valid from scanner (may be held for many cycles)
//   keyboard_num key code, valid while keyboard_en=1
//   bcd_value    packed BCD buffer, [3:0] = newest digit, empty nibbles = 0
//   digit_cnt    number of valid digits, 0..8
//   buf_full     high when digit_cnt == 8
//   led_en       active-low digit enables, exactly one bit low
//   led_seg      active-low segments {a,b,c,d,e,f,g}
module keypad_digit_display #(
  parameter int SCAN_DIV = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        keyboard_en,
  input  logic [3:0]  keyboard_num,
  output logic [31:0] bcd_value,
  output logic [3:0]  digit_cnt,
  output logic        buf_full,
  output logic [7:0]  led_en,
  output logic [6:0]  led_seg
);

  localparam int            CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] SCAN_ONE  = CW'(1);

  // Active-low segment pattern for one BCD digit; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic          r_en_q;
  logic [31:0]   r_bcd;
  logic [3:0]    r_cnt;
  logic          r_full;
  logic [CW-1:0] r_scan_cnt;
  logic [2:0]    r_scan_idx;
  logic [7:0]    r_led_en;
  logic [6:0]    r_led_seg;

  logic          w_accept;
  logic [31:0]   w_bcd_nxt;
  logic [3:0]    w_cnt_nxt;
  logic          w_wrap;
  logic [CW-1:0] w_scan_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [3:0]    w_nibble;
  logic          w_lit;
  logic [6:0]    w_seg_nxt;
  logic [7:0]    w_en_nxt;

  // Rising-edge detect on keyboard_en, then buffer edit for the accepted key.
  always_comb begin
    w_accept  = keyboard_en & ~r_en_q;
    w_bcd_nxt = r_bcd;
    w_cnt_nxt = r_cnt;
    if (w_accept) begin
      case (keyboard_num)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
        4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
          // A full buffer ignores further digits rather than wrapping.
          if (r_cnt < 4'd8) begin
            w_bcd_nxt = {r_bcd[27:0], keyboard_num};
            w_cnt_nxt = r_cnt + 4'd1;
          end else begin
            w_bcd_nxt = r_bcd;
            w_cnt_nxt = r_cnt;
          end
        end
        4'hB: begin
          if (r_cnt != 4'd0) begin
            w_bcd_nxt = {4'h0, r_bcd[31:4]};
            w_cnt_nxt = r_cnt - 4'd1;
          end else begin
            w_bcd_nxt = r_bcd;
            w_cnt_nxt = r_cnt;
          end
        end
        4'hC: begin
          w_bcd_nxt = 32'h0000_0000;
          w_cnt_nxt = 4'd0;
        end
        default: begin
          w_bcd_nxt = r_bcd;
          w_cnt_nxt = r_cnt;
        end
      endcase
    end else begin
      w_bcd_nxt = r_bcd;
      w_cnt_nxt = r_cnt;
    end
  end

  // Scan position and the segment data for the digit selected next cycle.
  // Segments are recomputed every cycle from the post-edit buffer, so an
  // edit shows immediately and a coincident wrap uses the new contents.
  always_comb begin
    w_wrap = (r_scan_cnt == SCAN_LAST);
    if (w_wrap) begin
      w_scan_cnt_nxt = {CW{1'b0}};
      w_idx_nxt      = r_scan_idx + 3'd1;
    end else begin
      w_scan_cnt_nxt = r_scan_cnt + SCAN_ONE;
      w_idx_nxt      = r_scan_idx;
    end
    w_nibble  = w_bcd_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_lit     = ({1'b0, w_idx_nxt} < w_cnt_nxt);
    w_seg_nxt = w_lit ? seg7(w_nibble) : 7'b1111111;
    w_en_nxt  = ~(8'b0000_0001 << w_idx_nxt);
  end

  // State registers. During reset en_q still tracks keyboard_en, so a key
  // held across reset is not taken as a fresh press once reset releases.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_en_q     <= keyboard_en;
      r_bcd      <= 32'h0000_0000;
      r_cnt      <= 4'd0;
      r_full     <= 1'b0;
      r_scan_cnt <= {CW{1'b0}};
      r_scan_idx <= 3'd0;
      r_led_en   <= 8'b1111_1110;
      r_led_seg  <= 7'b1111111;
    end else begin
      r_en_q     <= keyboard_en;
      r_bcd      <= w_bcd_nxt;
      r_cnt      <= w_cnt_nxt;
      r_full     <= (w_cnt_nxt == 4'd8);
      r_scan_cnt <= w_scan_cnt_nxt;
      r_scan_idx <= w_idx_nxt;
      r_led_en   <= w_en_nxt;
      r_led_seg  <= w_seg_nxt;
    end
  end

  assign bcd_value = r_bcd;
  assign digit_cnt = r_cnt;
  assign buf_full  = r_full;
  assign led_en    = r_led_en;
  assign led_seg   = r_led_seg;

endmodule

// File: tb/tb_keypad_digit_display.sv
// Testbench for keypad_digit_display (SCAN_DIV=4). It uses a scoreboard
// queue for key edits and a cycle-level display model.
module tb_keypad_digit_display;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        keyboard_en = 1'b0;
  logic [3:0]  keyboard_num = 4'h0;
  logic [31:0] bcd_value;
  logic [3:0]  digit_cnt;
  logic        buf_full;
  logic [7:0]  led_en;
  logic [6:0]  led_seg;

  keypad_digit_display #(.SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .keyboard_en(keyboard_en),
    .keyboard_num(keyboard_num), .bcd_value(bcd_value),
    .digit_cnt(digit_cnt), .buf_full(buf_full),
    .led_en(led_en), .led_seg(led_seg)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] bcd;
    logic [3:0]  cnt;
    logic        full;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_bcd = 32'h0;
  logic [3:0]  m_cnt = 4'd0;
  logic        m_en_q = 1'b0;
  int          m_n = 0;

  function automatic exp_t edit(input exp_t s, input logic [3:0] k);
    exp_t r;
    r = s;
    if (k <= 4'd9) begin
      if (s.cnt < 4'd8) begin
        r.bcd = {s.bcd[27:0], k};
        r.cnt = s.cnt + 4'd1;
      end
    end else if (k == 4'hB) begin
      if (s.cnt != 4'd0) begin
        r.bcd = {4'h0, s.bcd[31:4]};
        r.cnt = s.cnt - 4'd1;
      end
    end else if (k == 4'hC) begin
      r.bcd = 32'h0;
      r.cnt = 4'd0;
    end
    r.full = (r.cnt == 4'd8);
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int exp_idx();
    return (m_n / SD) % 8;
  endfunction

  function automatic logic [7:0] exp_en();
    logic [7:0] one;
    one = 8'b0000_0001;
    return ~(one << exp_idx());
  endfunction

  function automatic logic [6:0] exp_seg();
    int i;
    i = exp_idx();
    if (i < int'(m_cnt)) return seg_of(m_bcd[i*4 +: 4]);
    return 7'b1111111;
  endfunction

  // One clock: update the model at the edge, then settle before sampling.
  task automatic step();
    exp_t s;
    @(posedge clk);
    if (!reset) begin
      m_bcd = 32'h0; m_cnt = 4'd0; m_en_q = keyboard_en; m_n = 0;
    end else begin
      if (keyboard_en && !m_en_q) begin
        s = edit('{bcd: m_bcd, cnt: m_cnt, full: (m_cnt == 4'd8)}, keyboard_num);
        m_bcd = s.bcd;
        m_cnt = s.cnt;
      end
      m_en_q = keyboard_en;
      m_n++;
    end
    #1;
  endtask

  // Press a key: push the expected edit, check it at the accepting edge.
  task automatic press(input logic [3:0] k, input int hi, input int lo);
    exp_t e;
    e = edit('{bcd: m_bcd, cnt: m_cnt, full: (m_cnt == 4'd8)}, k);
    keyboard_num = k;
    keyboard_en  = 1'b1;
    sb_q.push_back(e);
    step();
    e = sb_q.pop_front();
    n_tests++;
    if (bcd_value !== e.bcd || digit_cnt !== e.cnt || buf_full !== e.full) begin
      n_fail++;
      $display("FAIL key_%h: got bcd=%h cnt=%0d full=%b want bcd=%h cnt=%0d full=%b",
               k, bcd_value, digit_cnt, buf_full, e.bcd, e.cnt, e.full);
    end
    for (int i = 1; i < hi; i++) step();
    keyboard_en = 1'b0;
    for (int i = 0; i < lo; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (bcd_value !== 32'h0 || digit_cnt !== 4'd0 || buf_full !== 1'b0 ||
        led_en !== 8'hFE || led_seg !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_state: got bcd=%h cnt=%0d full=%b en=%h seg=%h want 0 0 0 fe 7f",
               bcd_value, digit_cnt, buf_full, led_en, led_seg);
    end
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      n_tests++;
      if (led_en !== exp_en() || led_seg !== 7'h7F || bcd_value !== 32'h0) begin
        n_fail++;
        $display("FAIL scan_idle c=%0d: got en=%h seg=%h bcd=%h want en=%h seg=7f bcd=0",
                 c, led_en, led_seg, bcd_value, exp_en());
      end
    end
  endtask

  task automatic test_digit_entry();
    press(4'd1, 10, 5);
    press(4'd2, 10, 5);
    press(4'd3, 10, 5);
    n_tests++;
    if (bcd_value !== 32'h0000_0123 || digit_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL entry_123: got bcd=%h cnt=%0d want 00000123 3", bcd_value, digit_cnt);
    end
    for (int c = 0; c < 8 * SD; c++) begin
      step();
      n_tests++;
      if (led_en !== exp_en() || led_seg !== exp_seg()) begin
        n_fail++;
        $display("FAIL scan_123 c=%0d: got en=%h seg=%b want en=%h seg=%b",
                 c, led_en, led_seg, exp_en(), exp_seg());
      end
      if (led_en == 8'hFE || led_en == 8'hFB || led_en == 8'hF7) begin
        n_tests++;
        if ((led_en == 8'hFE && led_seg !== 7'b0000110) ||
            (led_en == 8'hFB && led_seg !== 7'b1001111) ||
            (led_en == 8'hF7 && led_seg !== 7'b1111111)) begin
          n_fail++;
          $display("FAIL seg_const en=%h: got seg=%b", led_en, led_seg);
        end
      end
    end
  endtask

  task automatic test_overflow();
    press(4'hC, 2, 1);
    for (int d = 1; d <= 9; d++) press(4'(d), 2, 1);
    n_tests++;
    if (bcd_value !== 32'h1234_5678 || digit_cnt !== 4'd8 || buf_full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: got bcd=%h cnt=%0d full=%b want 12345678 8 1",
               bcd_value, digit_cnt, buf_full);
    end
  endtask

  task automatic test_backspace_clear();
    press(4'hC, 2, 1);
    press(4'd1, 2, 1);
    press(4'd2, 2, 1);
    press(4'd3, 2, 1);
    press(4'hB, 3, 1);
    n_tests++;
    if (bcd_value !== 32'h12 || digit_cnt !== 4'd2 || buf_full !== 1'b0) begin
      n_fail++;
      $display("FAIL backspace: got bcd=%h cnt=%0d want 12 2", bcd_value, digit_cnt);
    end
    press(4'hC, 3, 1);
    n_tests++;
    if (bcd_value !== 32'h0 || digit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL clear: got bcd=%h cnt=%0d want 0 0", bcd_value, digit_cnt);
    end
    press(4'hB, 3, 1);
    n_tests++;
    if (bcd_value !== 32'h0 || digit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL bs_empty: got bcd=%h cnt=%0d want 0 0", bcd_value, digit_cnt);
    end
  endtask

  task automatic test_ignored_and_reset();
    press(4'd4, 2, 1);
    press(4'hA, 3, 1);
    press(4'hD, 3, 1);
    press(4'hE, 3, 1);
    press(4'hF, 3, 1);
    n_tests++;
    if (bcd_value !== 32'h4 || digit_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL ignored: got bcd=%h cnt=%0d want 4 1", bcd_value, digit_cnt);
    end
    keyboard_num = 4'd5;
    keyboard_en  = 1'b1;
    step();
    step();
    n_tests++;
    if (bcd_value !== 32'h45 || digit_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL pre_reset: got bcd=%h cnt=%0d want 45 2", bcd_value, digit_cnt);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_tests++;
    if (bcd_value !== 32'h0 || digit_cnt !== 4'd0 || buf_full !== 1'b0 ||
        led_en !== 8'hFE || led_seg !== 7'h7F) begin
      n_fail++;
      $display("FAIL mid_reset: got bcd=%h cnt=%0d full=%b en=%h seg=%h want 0 0 0 fe 7f",
               bcd_value, digit_cnt, buf_full, led_en, led_seg);
    end
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (bcd_value !== 32'h0 || digit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL held_after_reset: got bcd=%h cnt=%0d want 0 0", bcd_value, digit_cnt);
    end
    keyboard_en = 1'b0;
    step();
    press(4'd5, 2, 1);
    n_tests++;
    if (bcd_value !== 32'h5 || digit_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL repress: got bcd=%h cnt=%0d want 5 1", bcd_value, digit_cnt);
    end
  endtask

  task automatic test_wrap_edit();
    int k;
    press(4'hC, 2, 1);
    // Advance until the next edge is the wrap into digit 0.
    k = 0;
    while ((m_n % (8 * SD)) != (8 * SD - 1) && k < 64) begin
      step();
      k++;
    end
    n_tests++;
    if ((m_n % (8 * SD)) != (8 * SD - 1)) begin
      n_fail++;
      $display("FAIL wrap_align: timed out after %0d cycles", k);
    end
    press(4'd7, 1, 0);
    n_tests++;
    if (led_en !== 8'hFE || led_seg !== 7'b0001111) begin
      n_fail++;
      $display("FAIL wrap_edit: got en=%h seg=%b want fe 0001111", led_en, led_seg);
    end
    keyboard_en = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_digit_entry();
    test_overflow();
    test_backspace_clear();
    test_ignored_and_reset();
    test_wrap_edit();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
